// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
//
// Pipeline register between the decode and execute stages. It carries one
// instruction's payload and supports hold (stall), bubble insertion (flush),
// and an in-place Tnew countdown while a valid instruction is held. Two
// saturating counters report stalled and flushed cycles.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   stall_i, flush_i    : hold current contents / load a bubble (flush wins)
//   in_valid            : upstream slot holds a real instruction
//   in_pc .. in_imm     : DATA_W payload words
//   in_rs, in_rt, in_rd : register indices
//   in_tnew             : cycles until result is produced, counted at decode
//   out_*               : registered copies of the above, out_tnew after decrement
//   stall_cnt           : saturating count of stall cycles (flush not counted)
//   bubble_cnt          : saturating count of flush cycles
module id_ex_stage_reg #(
    parameter int unsigned DATA_W           = 32,
    parameter int unsigned REG_W            = 5,
    parameter int unsigned TNEW_W           = 2,
    parameter int unsigned TNEW_DEC         = 1,
    parameter int unsigned DEC_ON_HOLD      = 1,
    parameter int unsigned KEEP_PC_ON_FLUSH = 1,
    parameter int unsigned CNT_W            = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [TNEW_W-1:0] in_tnew,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] rs_val_q, rs_val_d;
    logic [DATA_W-1:0] rt_val_q, rt_val_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_W-1:0]  rs_q, rs_d;
    logic [REG_W-1:0]  rt_q, rt_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic              go_bubble;
    logic [31:0]       in_tnew_ext;
    logic [TNEW_W-1:0] load_tnew;

    // Saturating subtract of TNEW_DEC; done in 32 bits so TNEW_DEC may exceed the field.
    assign in_tnew_ext = 32'(in_tnew);
    assign load_tnew   = (in_tnew_ext >= TNEW_DEC) ? TNEW_W'(in_tnew_ext - TNEW_DEC) : '0;

    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        rs_val_d     = rs_val_q;
        rt_val_d     = rt_val_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        tnew_d       = tnew_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        go_bubble    = 1'b0;

        if (flush_i) begin
            go_bubble = 1'b1;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else if (stall_i) begin
            if (DEC_ON_HOLD != 0 && valid_q && tnew_q != '0) tnew_d = tnew_q - TNEW_W'(1);
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else if (in_valid) begin
            valid_d  = 1'b1;
            pc_d     = in_pc;
            instr_d  = in_instr;
            rs_val_d = in_rs_val;
            rt_val_d = in_rt_val;
            imm_d    = in_imm;
            rs_d     = in_rs;
            rt_d     = in_rt;
            rd_d     = in_rd;
            tnew_d   = load_tnew;
        end else begin
            // Invalid upstream slot: bubble, but not counted as a flush.
            go_bubble = 1'b1;
        end

        if (go_bubble) begin
            valid_d  = 1'b0;
            pc_d     = (KEEP_PC_ON_FLUSH != 0) ? in_pc : '0;
            instr_d  = '0;
            rs_val_d = '0;
            rt_val_d = '0;
            imm_d    = '0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
            tnew_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            instr_q      <= '0;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            tnew_q       <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            rs_val_q     <= rs_val_d;
            rt_val_q     <= rt_val_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            tnew_q       <= tnew_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_pc     = pc_q;
    assign out_instr  = instr_q;
    assign out_rs_val = rs_val_q;
    assign out_rt_val = rt_val_q;
    assign out_imm    = imm_q;
    assign out_rs     = rs_q;
    assign out_rt     = rt_q;
    assign out_rd     = rd_q;
    assign out_tnew   = tnew_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg (CNT_W=4 so counter saturation is reachable).
module tb_id_ex_stage_reg;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset, stall_i, flush_i, in_valid;
    logic [31:0] in_pc, in_instr, in_rs_val, in_rt_val, in_imm;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [1:0]  in_tnew;
    logic        out_valid;
    logic [31:0] out_pc, out_instr, out_rs_val, out_rt_val, out_imm;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [1:0]  out_tnew;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic        e_valid;
    logic [31:0] e_pc, e_instr, e_rsv, e_rtv, e_imm;
    logic [4:0]  e_rs, e_rt, e_rd;
    int          e_tnew, e_sc, e_bc;

    id_ex_stage_reg #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_tnew(in_tnew),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_tnew(out_tnew),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [185:0] obs_vec();
        return {out_valid, out_pc, out_instr, out_rs_val, out_rt_val, out_imm,
                out_rs, out_rt, out_rd, out_tnew, stall_cnt, bubble_cnt};
    endfunction

    // Slot contents for an empty slot: everything zero, pc kept (KEEP_PC_ON_FLUSH=1).
    task automatic model_empty_slot();
        e_valid = 0; e_pc = in_pc; e_instr = 0; e_rsv = 0; e_rtv = 0; e_imm = 0;
        e_rs = 0; e_rt = 0; e_rd = 0; e_tnew = 0;
    endtask

    // One clock edge of the behaviour, computed from current inputs.
    task automatic model_step();
        int sat = (1 << CW) - 1;
        if (reset) begin
            model_empty_slot();
            e_pc = 0; e_sc = 0; e_bc = 0;
        end else if (flush_i) begin
            model_empty_slot();
            e_bc = (e_bc + 1 > sat) ? sat : e_bc + 1;
        end else if (stall_i) begin
            if (e_valid && e_tnew > 0) e_tnew = e_tnew - 1;
            e_sc = (e_sc + 1 > sat) ? sat : e_sc + 1;
        end else if (!in_valid) begin
            model_empty_slot();
        end else begin
            e_valid = 1; e_pc = in_pc; e_instr = in_instr; e_rsv = in_rs_val;
            e_rtv = in_rt_val; e_imm = in_imm; e_rs = in_rs; e_rt = in_rt; e_rd = in_rd;
            e_tnew = (int'(in_tnew) >= 1) ? int'(in_tnew) - 1 : 0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload();
        in_pc = $urandom; in_instr = $urandom; in_rs_val = $urandom;
        in_rt_val = $urandom; in_imm = $urandom;
        in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
        in_tnew = 2'($urandom);
    endtask

    task automatic test_reset();
        rand_payload(); in_valid = 1; stall_i = 1; flush_i = 1; reset = 1;
        cycle(); cycle();
        n_tests++;
        if (obs_vec() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs_vec());
        end
        n_tests++;
        if (stall_cnt !== 0 || bubble_cnt !== 0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, bubble_cnt);
        end
        reset = 0; stall_i = 0; flush_i = 0;
    endtask

    task automatic test_load();
        rand_payload(); in_valid = 1;
        in_pc = 32'h3004; in_instr = 32'h8C220004; in_tnew = 2;
        cycle();
        n_tests++;
        if (out_pc !== 32'h3004 || out_instr !== 32'h8C220004 || out_tnew !== 2'd1
            || out_valid !== 1'b1 || out_rd !== in_rd || out_imm !== in_imm) begin
            n_fail++;
            $display("FAIL load: got pc=%h instr=%h tnew=%0d valid=%b expected 3004/8c220004/1/1",
                     out_pc, out_instr, out_tnew, out_valid);
        end
        in_tnew = 0;
        cycle();
        n_tests++;
        if (out_tnew !== 2'd0) begin
            n_fail++; $display("FAIL load_tnew_zero: got %0d expected 0", out_tnew);
        end
    endtask

    task automatic test_stall_countdown();
        logic [185:0] held;
        int exp_t[3] = '{1, 0, 0};
        logic [CW-1:0] sc0;
        rand_payload(); in_valid = 1; in_tnew = 3;
        cycle();
        n_tests++;
        if (out_tnew !== 2'd2) begin
            n_fail++; $display("FAIL stall_preload_tnew: got %0d expected 2", out_tnew);
        end
        held = obs_vec();
        sc0 = stall_cnt;
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            rand_payload(); in_valid = 1;
            cycle();
            n_tests++;
            if (int'(out_tnew) != exp_t[i]) begin
                n_fail++; $display("FAIL stall_tnew[%0d]: got %0d expected %0d", i, out_tnew, exp_t[i]);
            end
            n_tests++;
            if (obs_vec() >> (2 * CW + 2) !== held >> (2 * CW + 2)) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs_vec(), held);
            end
        end
        n_tests++;
        if (int'(stall_cnt) != int'(sc0) + 3) begin
            n_fail++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, int'(sc0) + 3);
        end
        stall_i = 0;
    endtask

    task automatic test_flush();
        logic [CW-1:0] sc0, bc0;
        sc0 = stall_cnt; bc0 = bubble_cnt;
        rand_payload(); in_valid = 1; in_pc = 32'h3010; flush_i = 1; stall_i = 1;
        cycle();
        n_tests++;
        if (out_valid !== 1'b0 || out_instr !== 0 || out_tnew !== 0 || out_pc !== 32'h3010
            || out_rs !== 0 || out_imm !== 0) begin
            n_fail++;
            $display("FAIL flush: got valid=%b instr=%h tnew=%0d pc=%h expected 0/0/0/3010",
                     out_valid, out_instr, out_tnew, out_pc);
        end
        n_tests++;
        if (int'(bubble_cnt) != int'(bc0) + 1 || stall_cnt !== sc0) begin
            n_fail++;
            $display("FAIL flush_counters: got bc=%0d sc=%0d expected %0d/%0d",
                     bubble_cnt, stall_cnt, int'(bc0) + 1, sc0);
        end
        flush_i = 0; stall_i = 0;
    endtask

    task automatic test_invalid_load();
        logic [CW-1:0] bc0;
        bc0 = bubble_cnt;
        rand_payload(); in_valid = 0; in_instr = 32'hFFFFFFFF; in_tnew = 3;
        cycle();
        n_tests++;
        if (out_valid !== 1'b0 || out_instr !== 0 || out_tnew !== 0 || bubble_cnt !== bc0
            || out_pc !== in_pc) begin
            n_fail++;
            $display("FAIL invalid_load: got valid=%b instr=%h bc=%0d expected 0/0/%0d",
                     out_valid, out_instr, bubble_cnt, bc0);
        end
    endtask

    task automatic test_saturation();
        rand_payload(); in_valid = 1; stall_i = 1;
        for (int i = 0; i < 20; i++) cycle();
        n_tests++;
        if (stall_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_reach: got %0d expected 15", stall_cnt);
        end
        cycle();
        n_tests++;
        if (stall_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_stay: got %0d expected 15", stall_cnt);
        end
        reset = 1;
        cycle();
        reset = 0; stall_i = 0;
        n_tests++;
        if (stall_cnt !== 0) begin
            n_fail++; $display("FAIL sat_reset: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [185:0] exp;
        for (int i = 0; i < 400; i++) begin
            rand_payload();
            in_valid = ($urandom_range(0, 3) != 0);
            stall_i  = ($urandom_range(0, 2) == 0);
            flush_i  = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 49) == 0);
            cycle();
            exp = {e_valid, e_pc, e_instr, e_rsv, e_rtv, e_imm, e_rs, e_rt, e_rd,
                   2'(e_tnew), CW'(e_sc), CW'(e_bc)};
            n_tests++;
            if (obs_vec() !== exp) begin
                n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp);
            end
        end
        reset = 0; stall_i = 0; flush_i = 0;
    endtask

    initial begin
        reset = 1; stall_i = 0; flush_i = 0; in_valid = 0;
        in_pc = 0; in_instr = 0; in_rs_val = 0; in_rt_val = 0; in_imm = 0;
        in_rs = 0; in_rt = 0; in_rd = 0; in_tnew = 0;
        e_valid = 0; e_pc = 0; e_instr = 0; e_rsv = 0; e_rtv = 0; e_imm = 0;
        e_rs = 0; e_rt = 0; e_rd = 0; e_tnew = 0; e_sc = 0; e_bc = 0;
        #2;
        test_reset();
        test_load();
        test_stall_countdown();
        test_flush();
        test_invalid_load();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
